ctrl_pipe_hazard: RTL

- Parametrised successor to the in-order control/forwarding pipeline.
- Carries the decoded control bundle from ID through EX, MEM and up to FWD_DEPTH retirement stages.
- Produces per-source forwarding selects for EX, detects load-use hazards, and resolves branches/jumps in MEM against the fetch-time prediction.
- New relative to the previous generation: external freeze, load-use bubble insertion, configurable source count and bypass depth, saturating hazard counters.

---
 rtl/ctrl_pipe_hazard_pkg.sv | 42 ++++
 rtl/ctrl_pipe_hazard_fwd_match.sv | 34 +++
 rtl/ctrl_pipe_hazard.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared constants for the control/forwarding pipeline: branch conditions,
// bypass select encodings and the bit layout of a pipeline stage record.
package ctrl_pipe_hazard_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Bypass select: 0 reads the register file, k picks stage k after EX.
    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_STAGE1 = 2'd1;

    // Fixed-width fields sit in the low bits; rd and ctrl follow at
    // REC_FIXED_W because their widths are module parameters.
    localparam int REC_VALID   = 0;
    localparam int REC_WEN     = 1;
    localparam int REC_LOAD    = 2;
    localparam int REC_BRANCH  = 3;
    localparam int REC_JUMP    = 4;
    localparam int REC_PRED    = 5;
    localparam int REC_EQ      = 6;
    localparam int REC_LT      = 7;
    localparam int REC_F3      = 8;
    localparam int REC_FIXED_W = 11;

    function automatic logic br_cond(input logic [2:0] funct3, input logic eq, input logic lt);
        logic cond;
        cond = 1'b0;
        case (funct3)
            BR_EQ:          cond = eq;
            BR_NE:          cond = !eq;
            BR_LT, BR_LTU:  cond = lt;
            BR_GE, BR_GEU:  cond = !lt;
            default:        cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_match.sv
// Bypass matcher for one EX source: picks the nearest younger producer
// stage whose qualified write enable and rd match the source register.
module ctrl_pipe_hazard_fwd_match
    import ctrl_pipe_hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2
) (
    input  logic [REG_AW-1:0]           rs,
    input  logic                        uses,
    input  logic [FWD_DEPTH-1:0]        byp_wen,
    input  logic [FWD_DEPTH*REG_AW-1:0] byp_rd,
    output logic [1:0]                  sel
);

    logic [FWD_DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_hit
            assign hit[gi] = byp_wen[gi] && (byp_rd[gi*REG_AW +: REG_AW] == rs);
        end
    endgenerate

    // Scan from the oldest stage towards MEM so the nearest match wins.
    always_comb begin
        sel = FWD_RF;
        if (uses && (rs != '0)) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (hit[k]) sel = FWD_STAGE1 + 2'(k);
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// In-order control pipeline: carries decoded control from ID to the last
// retirement stage, generates EX bypass selects, load-use stalls and MEM
// branch/jump resolution with saturating hazard counters.
module ctrl_pipe_hazard
    import ctrl_pipe_hazard_pkg::*;
#(
    parameter int CTRL_W    = 16,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_uses,
    input  logic                      id_reg_wen,
    input  logic                      id_is_load,
    input  logic                      id_is_branch,
    input  logic                      id_is_jump,
    input  logic [2:0]                id_funct3,
    input  logic                      id_pred_taken,
    input  logic                      ext_stall,
    input  logic                      br_eq,
    input  logic                      br_lt,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [CTRL_W-1:0]         mem_ctrl,
    output logic [CTRL_W-1:0]         wb_ctrl,
    output logic                      wb_reg_wen,
    output logic [REG_AW-1:0]         wb_rd,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_id,
    output logic                      redirect,
    output logic                      mispredict,
    output logic                      resolved,
    output logic                      actual_taken,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          mispred_cnt
);

    localparam int REC_RD   = REC_FIXED_W;
    localparam int REC_CTRL = REC_RD + REG_AW;
    localparam int REC_W    = REC_CTRL + CTRL_W;

    // Stage 0 is EX, 1 is MEM, FWD_DEPTH is the last retirement stage.
    logic [FWD_DEPTH:0][REC_W-1:0]  stage_reg, stage_next;
    logic [NUM_SRC*REG_AW-1:0]      ex_rs_reg, ex_rs_next;
    logic [NUM_SRC-1:0]             ex_uses_reg, ex_uses_next;
    logic [CNT_W-1:0]               stall_cnt_reg, mispred_cnt_reg;

    logic [FWD_DEPTH:0]             stage_wen;
    logic [FWD_DEPTH*REG_AW-1:0]    byp_rd;
    logic [REC_W-1:0]               id_rec, ex_cap;
    logic                           raw_redirect, raw_mispredict, raw_resolved;
    logic                           load_hazard, load_use, flush, cond;

    generate
        for (genvar gi = 0; gi <= FWD_DEPTH; gi++) begin : g_wen
            assign stage_wen[gi] = stage_reg[gi][REC_VALID] && stage_reg[gi][REC_WEN]
                                   && (stage_reg[gi][REC_RD +: REG_AW] != '0);
        end
        for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_byp
            assign byp_rd[(gi-1)*REG_AW +: REG_AW] = stage_reg[gi][REC_RD +: REG_AW];
        end
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            ctrl_pipe_hazard_fwd_match #(
                .REG_AW    (REG_AW),
                .FWD_DEPTH (FWD_DEPTH)
            ) u_fwd_match (
                .rs      (ex_rs_reg[gi*REG_AW +: REG_AW]),
                .uses    (ex_uses_reg[gi]),
                .byp_wen (stage_wen[FWD_DEPTH:1]),
                .byp_rd  (byp_rd),
                .sel     (fwd_sel[gi*2 +: 2])
            );
        end
    endgenerate

    // Branch/jump resolution on the MEM record.
    always_comb begin
        raw_redirect   = 1'b0;
        raw_mispredict = 1'b0;
        raw_resolved   = 1'b0;
        actual_taken   = 1'b0;
        cond = br_cond(stage_reg[1][REC_F3 +: 3], stage_reg[1][REC_EQ], stage_reg[1][REC_LT]);
        if (stage_reg[1][REC_VALID]) begin
            if (stage_reg[1][REC_JUMP]) begin
                actual_taken = 1'b1;
                raw_redirect = !stage_reg[1][REC_PRED];
            end else if (stage_reg[1][REC_BRANCH]) begin
                raw_resolved   = 1'b1;
                actual_taken   = cond;
                raw_mispredict = cond ^ stage_reg[1][REC_PRED];
                raw_redirect   = raw_mispredict;
            end
        end
    end

    always_comb begin
        load_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_uses[i] && (id_rs[i*REG_AW +: REG_AW] == stage_reg[0][REC_RD +: REG_AW]))
                load_hazard = 1'b1;
        end
        load_hazard = load_hazard && stage_wen[0] && stage_reg[0][REC_LOAD];
    end

    // A flush kills whatever would have been stalled behind the load.
    assign flush      = raw_redirect;
    assign load_use   = load_hazard && !flush;
    assign stall_id   = load_use && !ext_stall;
    assign redirect   = raw_redirect && !ext_stall;
    assign mispredict = raw_mispredict && !ext_stall;
    assign resolved   = raw_resolved && !ext_stall;

    always_comb begin
        id_rec = '0;
        id_rec[REC_VALID]           = id_valid;
        id_rec[REC_WEN]             = id_reg_wen;
        id_rec[REC_LOAD]            = id_is_load;
        id_rec[REC_BRANCH]          = id_is_branch;
        id_rec[REC_JUMP]            = id_is_jump;
        id_rec[REC_PRED]            = id_pred_taken;
        id_rec[REC_F3 +: 3]         = id_funct3;
        id_rec[REC_RD +: REG_AW]    = id_rd;
        id_rec[REC_CTRL +: CTRL_W]  = id_ctrl;

        ex_cap = stage_reg[0];
        ex_cap[REC_EQ] = br_eq;
        ex_cap[REC_LT] = br_lt;
    end

    always_comb begin
        stage_next   = stage_reg;
        ex_rs_next   = ex_rs_reg;
        ex_uses_next = ex_uses_reg;
        if (!ext_stall) begin
            if (flush || load_use) begin
                stage_next[0] = '0;
                ex_rs_next    = '0;
                ex_uses_next  = '0;
            end else begin
                stage_next[0] = id_rec;
                ex_rs_next    = id_rs;
                ex_uses_next  = id_uses;
            end
            stage_next[1] = flush ? '0 : ex_cap;
            for (int s = 2; s <= FWD_DEPTH; s++) begin
                stage_next[s] = stage_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg       <= '0;
            ex_rs_reg       <= '0;
            ex_uses_reg     <= '0;
            stall_cnt_reg   <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            stage_reg   <= stage_next;
            ex_rs_reg   <= ex_rs_next;
            ex_uses_reg <= ex_uses_next;
            if (stall_id && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (mispredict && (mispred_cnt_reg != '1))
                mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
        end
    end

    assign ex_ctrl     = stage_reg[0][REC_CTRL +: CTRL_W];
    assign mem_ctrl    = stage_reg[1][REC_CTRL +: CTRL_W];
    assign wb_ctrl     = stage_reg[FWD_DEPTH][REC_CTRL +: CTRL_W];
    assign wb_reg_wen  = stage_wen[FWD_DEPTH];
    assign wb_rd       = stage_reg[FWD_DEPTH][REC_RD +: REG_AW];
    assign stall_cnt   = stall_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule
